pattern_scan_unit: RTL

PATTERN_SCAN_UNIT -- requirements
Module: pattern_scan_unit

---
 rtl/pattern_scan_pkg.sv | 21 ++
 rtl/pattern_window_match.sv | 41 ++++
 rtl/pattern_scan_unit.sv | 126 ++++++++++++
 3 files changed

// File: rtl/pattern_scan_pkg.sv
// Shared types and constants for the pattern scan unit: FSM states, the
// fixed data-memory addresses of the pattern and result words, pattern width.
package pattern_scan_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_PAT,
        SCAN,
        WR_CTB,
        WR_CTO,
        WR_CTS,
        DONE
    } state_t;

    localparam int PAT_ADDR = 32;
    localparam int CTB_ADDR = 33;
    localparam int CTO_ADDR = 34;
    localparam int CTS_ADDR = 35;
    localparam int PAT_W    = 5;

endpackage

// File: rtl/pattern_window_match.sv
// Compares the 5-bit pattern against the four windows fully inside the
// current byte and the four windows straddling the previous/current byte pair.
module pattern_window_match
    import pattern_scan_pkg::*;
(
    input  logic [3:0]       prev,
    input  logic [7:0]       cur,
    input  logic [PAT_W-1:0] pat,
    input  logic             first,
    output logic [2:0]       in_cnt,
    output logic             any_hit,
    output logic [2:0]       cross_cnt
);

    // Only the low nibble of the previous byte can reach a crossing window.
    logic [11:0] pair;
    logic [3:0]  in_hit;
    logic [3:0]  cross_hit;

    assign pair = {prev, cur};

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_win
            assign in_hit[gi]    = (cur[7-gi -: PAT_W] == pat);
            assign cross_hit[gi] = !first && (pair[11-gi -: PAT_W] == pat);
        end
    endgenerate

    always_comb begin
        in_cnt    = 3'd0;
        cross_cnt = 3'd0;
        for (int i = 0; i < 4; i++) begin
            in_cnt    = in_cnt + {2'b00, in_hit[i]};
            cross_cnt = cross_cnt + {2'b00, cross_hit[i]};
        end
    end

    assign any_hit = |in_hit;

endmodule

// File: rtl/pattern_scan_unit.sv
// Scans a STR_BYTES-long message for a 5-bit pattern and writes the in-byte,
// per-byte-hit and whole-string match counts back to data memory.
module pattern_scan_unit
    import pattern_scan_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int STR_BYTES = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    output logic              done
);

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] index_reg;
    logic [PAT_W-1:0]  pat_reg;
    logic [3:0]        prev_reg;
    logic [7:0]        ctb_reg, cto_reg, cts_reg;

    logic [2:0] in_cnt, cross_cnt;
    logic       any_hit;
    logic       last_byte;

    assign last_byte = (index_reg == ADDR_W'(STR_BYTES - 1));

    pattern_window_match u_match (
        .prev      (prev_reg),
        .cur       (mem_rdata),
        .pat       (pat_reg),
        .first     (index_reg == '0),
        .in_cnt    (in_cnt),
        .any_hit   (any_hit),
        .cross_cnt (cross_cnt)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE, DONE: if (start) state_next = LOAD_PAT;
            LOAD_PAT:   state_next = SCAN;
            SCAN:       if (last_byte) state_next = WR_CTB;
            WR_CTB:     state_next = WR_CTO;
            WR_CTO:     state_next = WR_CTS;
            WR_CTS:     state_next = DONE;
            default:    state_next = IDLE;
        endcase
    end

    // All outputs decode from state, so reset clears them with the FSM.
    always_comb begin
        mem_addr  = '0;
        mem_we    = 1'b0;
        mem_wdata = 8'd0;
        done      = 1'b0;
        case (state_reg)
            LOAD_PAT: mem_addr = ADDR_W'(PAT_ADDR);
            SCAN:     mem_addr = index_reg;
            WR_CTB: begin
                mem_addr  = ADDR_W'(CTB_ADDR);
                mem_we    = 1'b1;
                mem_wdata = ctb_reg;
            end
            WR_CTO: begin
                mem_addr  = ADDR_W'(CTO_ADDR);
                mem_we    = 1'b1;
                mem_wdata = cto_reg;
            end
            WR_CTS: begin
                mem_addr  = ADDR_W'(CTS_ADDR);
                mem_we    = 1'b1;
                mem_wdata = cts_reg;
            end
            DONE:     done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            index_reg <= '0;
            pat_reg   <= '0;
            prev_reg  <= '0;
            ctb_reg   <= 8'd0;
            cto_reg   <= 8'd0;
            cts_reg   <= 8'd0;
        end else begin
            case (state_reg)
                IDLE, DONE: begin
                    if (start) begin
                        index_reg <= '0;
                        prev_reg  <= '0;
                        ctb_reg   <= 8'd0;
                        cto_reg   <= 8'd0;
                        cts_reg   <= 8'd0;
                    end
                end
                LOAD_PAT: begin
                    pat_reg   <= mem_rdata[7:3];
                    index_reg <= '0;
                end
                SCAN: begin
                    prev_reg <= mem_rdata[3:0];
                    ctb_reg  <= ctb_reg + {5'd0, in_cnt};
                    cto_reg  <= cto_reg + {7'd0, any_hit};
                    cts_reg  <= cts_reg + {5'd0, in_cnt} + {5'd0, cross_cnt};
                    if (!last_byte) index_reg <= index_reg + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
